// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   8N1 serial receiver with a first-word-fall-through byte FIFO.
//   The raw RX line is synchronised, frames are recovered with a fixed
//   bit-period counter, and good bytes are queued for a valid/ready consumer.
//
// Ports
//   wb_clk_i      in   1     single clock, rising edge
//   wb_rst_n      in   1     asynchronous active-low reset
//   rx_i          in   1     raw serial input (asynchronous, idle high)
//   rx_data_o     out  8     byte at FIFO head
//   rx_valid_o    out  1     FIFO non-empty
//   rx_ready_i    in   1     pop head when rx_valid_o is also high
//   fifo_count_o  out  AW+1  bytes stored
//   frame_err_o   out  1     sticky: a stop bit was sampled low
//   overrun_o     out  1     sticky: a byte was dropped on a full FIFO
//   clr_err_i     in   1     pulse clearing both sticky flags
//   irq_o         out  1     rx_valid_o | frame_err_o | overrun_o
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter  int CLKS_PER_BIT = 87,
  parameter  int FIFO_DEPTH   = 4,
  localparam int AW           = $clog2(FIFO_DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          rx_i,
  output logic [7:0]    rx_data_o,
  output logic          rx_valid_o,
  input  logic          rx_ready_i,
  output logic [AW:0]   fifo_count_o,
  output logic          frame_err_o,
  output logic          overrun_o,
  input  logic          clr_err_i,
  output logic          irq_o
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int              HALF      = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // Pointers differing only in the MSB means the writer is one lap ahead.
  localparam logic [AW:0]      FULL_XOR  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // Synchroniser and edge-detect delay; all reset to the idle (high) level.
  logic rx_meta_q, rx_s_q, rx_d_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bitn_q, bitn_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic push, frame_set, full, pop, wr_en, ovr_set;

  // --------------------------------------------------------------------------
  // Frame recovery FSM
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_LAST) begin
          if (rx_s_q) begin
            state_d = S_IDLE;           // start bit gone by mid-bit: glitch
          end else begin
            cnt_d   = '0;
            bitn_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (bitn_q == 3'd7) state_d = S_STOP;
          else                bitn_d  = bitn_q + 3'd1;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BIT_LAST) begin
          // Returning to IDLE on the sample cycle allows zero dead time. A
          // low stop bit leaves rx_d low, so a break cannot restart a frame.
          state_d   = S_IDLE;
          push      = rx_s_q;
          frame_set = !rx_s_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO and sticky flags
  // --------------------------------------------------------------------------
  always_comb begin
    full    = ((wptr_q ^ rptr_q) == FULL_XOR);
    pop     = rx_valid_o && rx_ready_i;
    // A simultaneous pop frees the slot being written, so a full push is fine.
    wr_en   = push && (!full || pop);
    ovr_set = push && full && !pop;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) begin
      mem_d[wptr_q[AW-1:0]] = shreg_q;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (pop) rptr_d = rptr_q + (AW+1)'(1);

    // Set is applied after clear so it wins a same-cycle collision.
    frame_err_d = (frame_err_q && !clr_err_i) || frame_set;
    overrun_d   = (overrun_q   && !clr_err_i) || ovr_set;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the storage array is reset too, because the head is exposed
      // combinationally and must read 0, not X, straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the synchroniser chain into one stage.
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      rx_d_q      <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      shreg_q     <= shreg_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      mem_q       <= mem_d;
    end
  end

  assign rx_data_o    = mem_q[rptr_q[AW-1:0]];
  assign rx_valid_o   = (wptr_q != rptr_q);
  assign fifo_count_o = wptr_q - rptr_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign irq_o        = rx_valid_o | frame_err_q | overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo with CLKS_PER_BIT=16, FIFO_DEPTH=4.
//   Bytes the FIFO should accept are queued when their stop bit is driven;
//   a monitor pops and compares them whenever the DUT completes a handshake.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;
  // Stop sample edge index relative to the edge after which start is driven:
  // 2 synchroniser edges + 1 detect + HALF + 9 bit periods.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_i;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic [AW:0]   fifo_count_o;
  logic          frame_err_o;
  logic          overrun_o;
  logic          clr_err_i;
  logic          irq_o;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    exp_q[$];
  logic          exp_overrun = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .fifo_count_o (fifo_count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .clr_err_i    (clr_err_i),
    .irq_o        (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && rx_valid_o && rx_ready_i) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'd0, rx_data_o}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'd0, rx_data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // mode 0: plain frame; 1: ready high exactly on the stop-sample edge and the
  // one after; 2: reset asserted during data bit 3.
  task automatic send_frame(input logic [7:0] b, input bit stop_low, input int mode);
    logic [9:0] bits;
    bits = {~stop_low, b, 1'b0};
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk); #1;
      rx_i = bits[c / CPB];
      if (mode == 2 && c == 4 * CPB + CPB / 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check("rst_data",  {24'd0, rx_data_o}, 32'd0);
        check("rst_count", {29'd0, fifo_count_o}, 32'd0);
        check("rst_irq",   {31'd0, irq_o}, 32'd0);
        exp_q.delete();
        rx_i = 1'b1;
        return;
      end
      if (mode == 1 && c == STOP_EDGE - 1) rx_ready_i = 1'b1;
      if (mode == 1 && c == STOP_EDGE + 1) rx_ready_i = 1'b0;
      if (c == STOP_EDGE) begin
        // The monitor has already retired any same-edge pop, so the queue
        // size is the occupancy the push sees.
        if (!stop_low) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else                      exp_overrun = 1'b1;
        end
      end
      if (mode == 1 && c == STOP_EDGE) begin
        @(negedge clk);
        check("simul_count", {29'd0, fifo_count_o}, 32'd4);
        check("simul_no_ovr", {31'd0, overrun_o}, 32'd0);
      end
      if (mode == 1 && c == STOP_EDGE + 1) begin
        @(negedge clk);
        check("simul_count_after", {29'd0, fifo_count_o}, 32'd3);
      end
    end
    if (stop_low) begin
      @(posedge clk); #1;
      rx_i = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    @(posedge clk); #1;
    rx_ready_i = 1'b1;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!rx_valid_o) break;
      n++;
    end
    rx_ready_i = 1'b0;
    check({tag, "_drained_valid"}, {31'd0, rx_valid_o}, 32'd0);
    check({tag, "_drained_queue"}, exp_q.size(), 32'd0);
  endtask

  task automatic clear_errors();
    @(posedge clk); #1;
    clr_err_i = 1'b1;
    @(posedge clk); #1;
    clr_err_i   = 1'b0;
    exp_overrun = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst_n      = 1'b0;
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    clr_err_i  = 1'b0;
    idle(3);

    // Reset state
    check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    check("reset_data",  {24'd0, rx_data_o}, 32'd0);
    check("reset_count", {29'd0, fifo_count_o}, 32'd0);
    check("reset_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("reset_ovr",   {31'd0, overrun_o}, 32'd0);
    check("reset_irq",   {31'd0, irq_o}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single frame
    send_frame(8'hA5, 1'b0, 0);
    @(negedge clk);
    check("single_valid", {31'd0, rx_valid_o}, 32'd1);
    check("single_data",  {24'd0, rx_data_o}, 32'h A5);
    check("single_count", {29'd0, fifo_count_o}, 32'd1);
    check("single_irq",   {31'd0, irq_o}, 32'd1);
    check("single_errs",  {30'd0, frame_err_o, overrun_o}, 32'd0);
    @(posedge clk); #1; rx_ready_i = 1'b1;
    @(posedge clk); #1; rx_ready_i = 1'b0;
    @(negedge clk);
    check("single_pop_valid", {31'd0, rx_valid_o}, 32'd0);
    check("single_pop_count", {29'd0, fifo_count_o}, 32'd0);

    // Glitch rejection
    @(posedge clk); #1; rx_i = 1'b0;
    idle(4);            rx_i = 1'b1;
    idle(30);
    check("glitch_valid", {31'd0, rx_valid_o}, 32'd0);
    check("glitch_count", {29'd0, fifo_count_o}, 32'd0);
    check("glitch_irq",   {31'd0, irq_o}, 32'd0);

    // Frame error, clear, then a good frame
    send_frame(8'h3C, 1'b1, 0);
    @(negedge clk);
    check("ferr_flag",  {31'd0, frame_err_o}, 32'd1);
    check("ferr_irq",   {31'd0, irq_o}, 32'd1);
    check("ferr_count", {29'd0, fifo_count_o}, 32'd0);
    clear_errors();
    @(negedge clk);
    check("ferr_cleared", {31'd0, frame_err_o}, 32'd0);
    check("ferr_irq_clr", {31'd0, irq_o}, 32'd0);
    idle(3);
    send_frame(8'h55, 1'b0, 0);
    @(negedge clk);
    check("after_ferr_data", {24'd0, rx_data_o}, 32'h55);
    drain("after_ferr");

    // Overrun: five back-to-back frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 0);
    @(negedge clk);
    check("ovr_count", {29'd0, fifo_count_o}, 32'd4);
    check("ovr_flag",  {31'd0, overrun_o}, {31'd0, exp_overrun});
    drain("ovr");
    clear_errors();
    @(negedge clk);
    check("ovr_cleared", {31'd0, overrun_o}, 32'd0);

    // Full FIFO with a pop on the push edge
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b0, 0);
    send_frame(8'h20, 1'b0, 1);
    drain("simul");
    check("simul_ovr_final", {31'd0, overrun_o}, 32'd0);

    // Streaming with continuous ready: pointers wrap several times
    @(posedge clk); #1; rx_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b0, 0);
    end
    idle(4);
    rx_ready_i = 1'b0;
    check("stream_queue", exp_q.size(), 32'd0);
    check("stream_errs",  {30'd0, frame_err_o, overrun_o}, 32'd0);

    // Reset mid-frame with two bytes queued
    send_frame(8'hC3, 1'b0, 0);
    send_frame(8'h3A, 1'b0, 0);
    @(negedge clk);
    check("prerst_count", {29'd0, fifo_count_o}, 32'd2);
    send_frame(8'h99, 1'b0, 2);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check("postrst_count", {29'd0, fifo_count_o}, 32'd0);
    send_frame(8'h7E, 1'b0, 0);
    @(negedge clk);
    check("postrst_count1", {29'd0, fifo_count_o}, 32'd1);
    check("postrst_data",   {24'd0, rx_data_o}, 32'h7E);
    drain("postrst");
    check("postrst_errs", {30'd0, frame_err_o, overrun_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
